// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
// State enum, requester ID type and read-return pipeline stage layout.
package sram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ_0 = 1'b0;
  localparam req_id_t REQ_1 = 1'b1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } ret_stage_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin grant: combinational readies, pointer moves to the
// requester that was not just accepted.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_enable,
  input  logic    i_valid0,
  input  logic    i_valid1,
  output logic    o_ready0,
  output logic    o_ready1,
  output logic    o_grant,
  output req_id_t o_grant_id
);

  req_id_t r_ptr;

  assign o_ready0   = i_enable && i_valid0 && (!i_valid1 || (r_ptr == REQ_0));
  assign o_ready1   = i_enable && i_valid1 && (!i_valid0 || (r_ptr == REQ_1));
  assign o_grant    = o_ready0 || o_ready1;
  assign o_grant_id = o_ready0 ? REQ_0 : REQ_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= REQ_0;
    end else if (o_grant) begin
      r_ptr <= other_req(o_grant_id);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a synchronous SRAM with 2-cycle read return.
// Define SRAM_ARB_CLEAR_EN to zero the whole SRAM after every reset.
//
// Handshake: a request is taken on a rising edge where rN_valid && rN_ready;
// rN_ready is combinational and at most one requester sees it per cycle.
// Read data comes back on rN_rvalid/rN_rdata as a one-cycle pulse, no backpressure.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ready,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ready,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy,
  output arb_state_e            o_dbg_state
);

  logic                  w_clearing;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_grant;
  req_id_t               w_grant_id;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  logic                  r_sram_we;
  logic                  r_sram_oe;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_din;
  ret_stage_t            r_s1;
  ret_stage_t            r_s2;
  logic                  r_r0_rvalid;
  logic                  r_r1_rvalid;
  logic [DATA_WIDTH-1:0] r_r0_rdata;
  logic [DATA_WIDTH-1:0] r_r1_rdata;

`ifdef SRAM_ARB_CLEAR_EN
  arb_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  // One zero-write per cycle; leave CLEAR after the top address is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
      if (&r_clr_addr) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_clr_addr  = r_clr_addr;
  assign o_dbg_state = r_state;
`else
  assign w_clearing  = 1'b0;
  assign w_clr_addr  = '0;
  assign o_dbg_state = ST_RUN;
`endif

  assign busy = w_clearing;

  sram_arb_rr u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (!w_clearing),
    .i_valid0   (r0_valid),
    .i_valid1   (r1_valid),
    .o_ready0   (r0_ready),
    .o_ready1   (r1_ready),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign w_sel_we    = (w_grant_id == REQ_0) ? r0_we    : r1_we;
  assign w_sel_addr  = (w_grant_id == REQ_0) ? r0_addr  : r1_addr;
  assign w_sel_wdata = (w_grant_id == REQ_0) ? r0_wdata : r1_wdata;

  // Strobes are single-cycle; address and data hold between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sram_we   <= 1'b0;
      r_sram_oe   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
    end else if (w_clearing) begin
      r_sram_we   <= 1'b1;
      r_sram_oe   <= 1'b0;
      r_sram_addr <= w_clr_addr;
      r_sram_din  <= '0;
    end else if (w_grant) begin
      r_sram_we   <= w_sel_we;
      r_sram_oe   <= !w_sel_we;
      r_sram_addr <= w_sel_addr;
      r_sram_din  <= w_sel_wdata;
    end else begin
      r_sram_we   <= 1'b0;
      r_sram_oe   <= 1'b0;
    end
  end

  // s1 covers the SRAM command cycle, s2 the SRAM access cycle; dout is
  // captured on the edge that retires s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1.valid <= 1'b0;
      r_s1.id    <= REQ_0;
      r_s2.valid <= 1'b0;
      r_s2.id    <= REQ_0;
    end else begin
      r_s1.valid <= w_grant && !w_sel_we;
      r_s1.id    <= w_grant_id;
      r_s2       <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_rdata  <= '0;
      r_r1_rdata  <= '0;
    end else begin
      r_r0_rvalid <= r_s2.valid && (r_s2.id == REQ_0);
      r_r1_rvalid <= r_s2.valid && (r_s2.id == REQ_1);
      if (r_s2.valid && (r_s2.id == REQ_0)) begin
        r_r0_rdata <= sram_dout;
      end
      if (r_s2.valid && (r_s2.id == REQ_1)) begin
        r_r1_rdata <= sram_dout;
      end
    end
  end

  assign sram_we   = r_sram_we;
  assign sram_oe   = r_sram_oe;
  assign sram_addr = r_sram_addr;
  assign sram_din  = r_sram_din;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM device, transaction-level reference
// model checked every cycle, directed scenarios plus randomized traffic.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_ARB_CLEAR_EN
  localparam logic RST_BUSY  = 1'b1;
  localparam int   RST_CLEAR = DEPTH;
`else
  localparam logic RST_BUSY  = 1'b0;
  localparam int   RST_CLEAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid, r0_we, r0_ready, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_we, r1_ready, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          sram_we, sram_oe, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  arb_state_e    dbg_state;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM device; the pl_* port preloads contents from the bench.
  logic [DW-1:0] dev_mem [DEPTH];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_we) dev_mem[pl_addr] <= pl_data;
    else if (sram_we) dev_mem[sram_addr] <= sram_din;
    if (sram_oe) sram_dout <= dev_mem[sram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: memory image, pending returns, expected pins.
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            ptr, edge_n, clear_left, rv_seen;
  logic          exp_we, exp_oe;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  logic [DW-1:0] exp_rdata [2];
  int            grant_log[$];
  logic [DW-1:0] obs0_q[$];
  logic [DW-1:0] obs1_q[$];

  always @(negedge clk) begin : model
    logic er0, er1, rv0, rv1, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int gid;
    if (rst) begin
      chk("rst_sram_we", sram_we, 0);
      chk("rst_sram_oe", sram_oe, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_din", sram_din, 0);
      chk("rst_r0_rvalid", r0_rvalid, 0);
      chk("rst_r1_rvalid", r1_rvalid, 0);
      chk("rst_r0_rdata", r0_rdata, 0);
      chk("rst_r1_rdata", r1_rdata, 0);
      chk("rst_busy", busy, RST_BUSY);
      ptr = 0; edge_n = 0; exp_q.delete();
      exp_we = 0; exp_oe = 0; exp_addr = '0; exp_din = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      clear_left = RST_CLEAR;
    end else begin
      if (pl_we) ref_mem[pl_addr] = pl_data;
      chk("sram_we", sram_we, exp_we);
      chk("sram_oe", sram_oe, exp_oe);
      chk("sram_addr", sram_addr, exp_addr);
      chk("sram_din", sram_din, exp_din);
      rv0 = 0; rv1 = 0;
      if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
        if (exp_q[0].id == 0) rv0 = 1; else rv1 = 1;
        exp_rdata[exp_q[0].id] = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      chk("r0_rvalid", r0_rvalid, rv0);
      chk("r1_rvalid", r1_rvalid, rv1);
      chk("r0_rdata", r0_rdata, exp_rdata[0]);
      chk("r1_rdata", r1_rdata, exp_rdata[1]);
      if (r0_rvalid) obs0_q.push_back(r0_rdata);
      if (r1_rvalid) obs1_q.push_back(r1_rdata);
      if (r0_rvalid || r1_rvalid) rv_seen++;
      chk("busy", busy, clear_left > 0);
      chk("dbg_state", dbg_state, (clear_left > 0) ? ST_CLEAR : ST_RUN);
      er0 = (clear_left == 0) && r0_valid && (!r1_valid || ptr == 0);
      er1 = (clear_left == 0) && r1_valid && (!r0_valid || ptr == 1);
      chk("r0_ready", r0_ready, er0);
      chk("r1_ready", r1_ready, er1);
      exp_we = 0; exp_oe = 0;
      if (clear_left > 0) begin
        exp_we = 1; exp_addr = AW'(DEPTH - clear_left); exp_din = '0;
        ref_mem[exp_addr] = '0;
        clear_left--;
      end else if (er0 || er1) begin
        gid = er0 ? 0 : 1;
        w = er0 ? r0_we : r1_we;
        a = er0 ? r0_addr : r1_addr;
        d = er0 ? r0_wdata : r1_wdata;
        grant_log.push_back(gid);
        ptr = 1 - gid;
        exp_addr = a; exp_din = d;
        if (w) begin
          exp_we = 1; ref_mem[a] = d;
        end else begin
          exp_oe = 1;
          exp_q.push_back('{due: edge_n + 3, id: gid, data: ref_mem[a]});
        end
      end
      edge_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic reset_assert();
    rst = 1;
    idle_inputs();
    step();
    step();
  endtask

  task automatic wait_clear();
    int n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
`ifdef SRAM_ARB_CLEAR_EN
    chk("clear_cycles", n, DEPTH);
`else
    chk("clear_cycles", n, 0);
`endif
  endtask

  task automatic preload_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we = 1; pl_addr = a; pl_data = d;
    step();
    pl_we = 0;
  endtask

  task automatic drive_r0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_valid = 1; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive_r1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_valid = 1; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  int exp_g [6] = '{0, 1, 0, 1, 0, 1};
  logic [DW-1:0] exp_seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    idle_inputs();
    step();
    step();
    rst = 0;
    wait_clear();
    for (int a = 0; a < 48; a++) preload_word(AW'(a), DW'($urandom));

    // Reset pulsed the cycle after a read is accepted: nothing may come back.
    drive_r0(1'b0, 8'h05, 8'h00);
    step();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    rv_seen = 0;
    wait_clear();
    repeat (6) step();
    chk("rst_discard_rvalids", rv_seen, 0);

    reset_assert();
`ifdef SRAM_ARB_CLEAR_EN
    rst = 0;
    wait_clear();
    obs0_q.delete();
    drive_r0(1'b0, 8'hA7, 8'h00);
    step();
    idle_inputs();
    repeat (4) step();
    chk("clear_read_count", obs0_q.size(), 1);
    if (obs0_q.size() == 1) chk("clear_read_a7", obs0_q[0], 8'h00);
`else
    rst = 0;
    drive_r0(1'b0, 8'h20, 8'h00);
    #1;
    chk("first_edge_ready", r0_ready, 1);
    step();
    idle_inputs();
    repeat (4) step();
`endif

    // Write then read-after-write from the other requester.
    obs0_q.delete();
    drive_r0(1'b1, 8'h10, 8'h5A);
    step();
    idle_inputs();
    drive_r1(1'b0, 8'h10, 8'h00);
    step();
    idle_inputs();
    step();
    step();
    chk("raw_r1_rvalid", r1_rvalid, 1);
    chk("raw_r1_rdata", r1_rdata, 8'h5A);
    chk("raw_r0_rvalid", r0_rvalid, 0);
    step();
    chk("raw_r1_rvalid_drop", r1_rvalid, 0);
    chk("raw_r0_no_return", obs0_q.size(), 0);

    // Both requesters contend for six cycles.
    preload_word(8'h01, 8'hA1);
    preload_word(8'h02, 8'hB2);
    grant_log.delete(); obs0_q.delete(); obs1_q.delete();
    drive_r0(1'b0, 8'h01, 8'h00);
    drive_r1(1'b0, 8'h02, 8'h00);
    repeat (6) step();
    idle_inputs();
    repeat (4) step();
    chk("rr_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr_grant_order", grant_log[i], exp_g[i]);
    chk("rr_r0_returns", obs0_q.size(), 3);
    chk("rr_r1_returns", obs1_q.size(), 3);
    for (int i = 0; i < obs0_q.size(); i++) chk("rr_r0_data", obs0_q[i], 8'hA1);
    for (int i = 0; i < obs1_q.size(); i++) chk("rr_r1_data", obs1_q[i], 8'hB2);

    // Four back-to-back reads from one requester.
    for (int a = 0; a < 4; a++) preload_word(AW'(a), exp_seq[a]);
    obs0_q.delete();
    for (int a = 0; a < 4; a++) begin
      drive_r0(1'b0, AW'(a), 8'h00);
      step();
    end
    idle_inputs();
    repeat (4) step();
    chk("burst_count", obs0_q.size(), 4);
    for (int i = 0; i < 4 && i < obs0_q.size(); i++) chk("burst_data", obs0_q[i], exp_seq[i]);

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        reset_assert();
        rst = 0;
        wait_clear();
      end
      r0_valid = ($urandom_range(0, 3) != 0);
      r0_we    = 1'($urandom_range(0, 1));
      r0_addr  = AW'($urandom_range(0, 15));
      r0_wdata = DW'($urandom);
      r1_valid = ($urandom_range(0, 3) != 0);
      r1_we    = 1'($urandom_range(0, 1));
      r1_addr  = AW'($urandom_range(0, 15));
      r1_wdata = DW'($urandom);
      step();
    end
    idle_inputs();
    repeat (5) step();
    chk("returns_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
